// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, FSM state type and flag helpers for the ALU sequencer
//
// Contents:
//   OP_*            4-bit ALU operation codes (same encoding as the datapath alu)
//   F_*             bit positions of the six status flags inside FLAGS
//   FLAGS_ONES      bits that always read 1 (1, 12..15)
//   FLAGS_ZEROS     bits that always read 0 (3, 5)
//   FLAGS_RESET     FLAGS value after reset
//   seq_state_t     sequencer FSM states
//   flag_update_mask(op)  which FLAGS bits an operation writes back
//   flags_fix(v)          force the fixed bits of a FLAGS value
package alu_pkg;

    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_NOT  = 4'b0001;
    localparam logic [3:0] OP_INC  = 4'b0010;
    localparam logic [3:0] OP_DEC  = 4'b0011;
    localparam logic [3:0] OP_INC2 = 4'b0100;
    localparam logic [3:0] OP_DEC2 = 4'b0101;
    localparam logic [3:0] OP_NEG  = 4'b0110;
    localparam logic [3:0] OP_RSVD = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_ADC  = 4'b1010;
    localparam logic [3:0] OP_SBB  = 4'b1011;
    localparam logic [3:0] OP_AND  = 4'b1100;
    localparam logic [3:0] OP_SUB  = 4'b1101;
    localparam logic [3:0] OP_XOR  = 4'b1110;
    localparam logic [3:0] OP_CMP  = 4'b1111;

    localparam int F_CF = 0;
    localparam int F_PF = 2;
    localparam int F_AF = 4;
    localparam int F_ZF = 6;
    localparam int F_SF = 7;
    localparam int F_OF = 11;

    localparam logic [15:0] FLAGS_ONES  = 16'hF002;
    localparam logic [15:0] FLAGS_ZEROS = 16'h0028;
    localparam logic [15:0] FLAGS_RESET = 16'hF002;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_COMMIT = 2'd2
    } seq_state_t;

    function automatic logic [15:0] flag_update_mask(input logic [3:0] op);
        logic [15:0] m;
        m = 16'h0000;
        case (op)
            OP_INC, OP_DEC: begin
                // INC/DEC leave CF alone so multi-word loops keep their carry.
                m[F_OF] = 1'b1;
                m[F_SF] = 1'b1;
                m[F_ZF] = 1'b1;
                m[F_AF] = 1'b1;
                m[F_PF] = 1'b1;
            end
            OP_NEG, OP_ADD, OP_OR, OP_ADC, OP_SBB,
            OP_AND, OP_SUB, OP_XOR, OP_CMP: begin
                m[F_OF] = 1'b1;
                m[F_SF] = 1'b1;
                m[F_ZF] = 1'b1;
                m[F_AF] = 1'b1;
                m[F_PF] = 1'b1;
                m[F_CF] = 1'b1;
            end
            OP_PASS, OP_NOT, OP_INC2, OP_DEC2, OP_RSVD: m = 16'h0000;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    function automatic logic [15:0] flags_fix(input logic [15:0] v);
        return (v & ~FLAGS_ZEROS) | FLAGS_ONES;
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request/result/FLAGS bus between execution unit and ALU sequencer
//
// Signals:
//   req_valid/req_ready      request handshake (accept when both high)
//   req_op/req_a/req_b/req_word  request payload, sampled on the accept edge
//   res_valid                one-cycle result pulse
//   res_data/res_write       result and its writeback qualifier
//   flags                    architectural FLAGS
//   flags_wr_en/flags_wr_data  direct FLAGS load (POPF/SAHF)
// Modports: master = execution unit, slave = sequencer.
interface alu_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_word;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_write;
    logic [15:0] flags;
    logic        flags_wr_en;
    logic [15:0] flags_wr_data;

    modport master (
        output req_valid, req_op, req_a, req_b, req_word, flags_wr_en, flags_wr_data,
        input  req_ready, res_valid, res_data, res_write, flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_word, flags_wr_en, flags_wr_data,
        output req_ready, res_valid, res_data, res_write, flags
    );

endinterface

// File: rtl/alu_sequencer_flags.sv
// rtl/alu_sequencer_flags.sv - architectural FLAGS register with masked merge and direct load
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   commit          high in the COMMIT cycle; merges status under the op's mask
//   op              operation being committed
//   status          ALU status flags placed at their FLAGS bit positions
//   wr_en, wr_data  direct load; takes priority over commit for every bit
//   flags           current FLAGS value
module alu_sequencer_flags
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        commit,
    input  logic [3:0]  op,
    input  logic [15:0] status,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic [15:0] flags
);

    logic [15:0] mask;
    logic [15:0] merged;

    always_comb begin
        mask   = flag_update_mask(op);
        merged = flags_fix((flags & ~mask) | (status & mask));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= FLAGS_RESET;
        end else if (wr_en) begin
            flags <= flags_fix(wr_data);
        end else if (commit) begin
            flags <= merged;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issue-side controller for the 8088 datapath ALU pipeline
//
// Ports:
//   CLKx4, RESET            clock, synchronous active-high reset
//   bus (slave)             request/result/FLAGS bus from the execution unit
//   alu_A, alu_B, alu_op    operands and operation driven to the ALU (0 in IDLE)
//   alu_byteWord            1 = 16-bit operation
//   alu_carryIn             CF captured at accept time
//   alu_S                   ALU result
//   alu_F_*                 ALU status flags, already width-qualified
// Parameter HOLD_CYCLES: cycles the ALU inputs stay stable before flags are sampled.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int HOLD_CYCLES = 3
) (
    input  logic            CLKx4,
    input  logic            RESET,
    alu_sequencer_if.slave  bus,
    output logic [15:0]     alu_A,
    output logic [15:0]     alu_B,
    output logic [3:0]      alu_op,
    output logic            alu_byteWord,
    output logic            alu_carryIn,
    input  logic [15:0]     alu_S,
    input  logic            alu_F_Overflow,
    input  logic            alu_F_Neg,
    input  logic            alu_F_Zero,
    input  logic            alu_F_Aux,
    input  logic            alu_F_Parity,
    input  logic            alu_F_Carry
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic [15:0]   status;

    always_comb begin
        status       = 16'h0000;
        status[F_OF] = alu_F_Overflow;
        status[F_SF] = alu_F_Neg;
        status[F_ZF] = alu_F_Zero;
        status[F_AF] = alu_F_Aux;
        status[F_PF] = alu_F_Parity;
        status[F_CF] = alu_F_Carry;
    end

    // The ALU drive registers double as the latched request; clearing them
    // on the way back to IDLE gives the all-zero idle drive.
    always_ff @(posedge CLKx4) begin
        if (RESET) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            alu_A         <= 16'h0000;
            alu_B         <= 16'h0000;
            alu_op        <= OP_PASS;
            alu_byteWord  <= 1'b0;
            alu_carryIn   <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= 16'h0000;
            bus.res_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.res_valid <= 1'b0;
                    if (bus.req_valid) begin
                        alu_A         <= bus.req_a;
                        alu_B         <= bus.req_b;
                        alu_op        <= bus.req_op;
                        alu_byteWord  <= bus.req_word;
                        // CF is frozen here so a FLAGS load during HOLD
                        // cannot disturb an in-flight ADC/SBB.
                        alu_carryIn   <= bus.flags[F_CF];
                        cnt           <= CW'(HOLD_CYCLES - 1);
                        bus.req_ready <= 1'b0;
                        state         <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        // Result is stable by the last HOLD cycle; it is
                        // registered here so res_data is valid throughout COMMIT.
                        bus.res_valid <= 1'b1;
                        bus.res_data  <= alu_byteWord ? alu_S : {8'h00, alu_S[7:0]};
                        bus.res_write <= (alu_op != OP_CMP);
                        state         <= ST_COMMIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_COMMIT: begin
                    bus.res_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    alu_A         <= 16'h0000;
                    alu_B         <= 16'h0000;
                    alu_op        <= OP_PASS;
                    alu_byteWord  <= 1'b0;
                    alu_carryIn   <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.res_valid <= 1'b0;
                end
            endcase
        end
    end

    // Flags are sampled on the COMMIT edge, one cycle after the result,
    // matching the ALU's extra flag register stage.
    alu_sequencer_flags u_flags (
        .clk     (CLKx4),
        .rst     (RESET),
        .commit  (state == ST_COMMIT),
        .op      (alu_op),
        .status  (status),
        .wr_en   (bus.flags_wr_en),
        .wr_data (bus.flags_wr_data),
        .flags   (bus.flags)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a pipelined ALU model
module tb_alu_sequencer;

    localparam int HOLD = 3;

    logic        CLKx4;
    logic        RESET;
    logic [15:0] alu_A, alu_B, alu_S;
    logic [3:0]  alu_op;
    logic        alu_byteWord, alu_carryIn;
    logic        f_of, f_sf, f_zf, f_af, f_pf, f_cf;

    int vecs;
    int errs;

    alu_sequencer_if bus ();

    alu_sequencer #(.HOLD_CYCLES(HOLD)) dut (
        .CLKx4          (CLKx4),
        .RESET          (RESET),
        .bus            (bus),
        .alu_A          (alu_A),
        .alu_B          (alu_B),
        .alu_op         (alu_op),
        .alu_byteWord   (alu_byteWord),
        .alu_carryIn    (alu_carryIn),
        .alu_S          (alu_S),
        .alu_F_Overflow (f_of),
        .alu_F_Neg      (f_sf),
        .alu_F_Zero     (f_zf),
        .alu_F_Aux      (f_af),
        .alu_F_Parity   (f_pf),
        .alu_F_Carry    (f_cf)
    );

    initial CLKx4 = 1'b0;
    always #5 CLKx4 = ~CLKx4;

    // Behavioural ALU: returns {OF,SF,ZF,AF,PF,CF,result}.
    function automatic logic [21:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] op, input logic w, input logic cin);
        logic [15:0] x, y, r;
        logic [16:0] full;
        logic        sub, arith, c, cf, of, af;
        int          m;
        x = a; y = b; r = 16'h0; c = 1'b0; sub = 1'b0; arith = 1'b1; full = 17'h0;
        case (op)
            4'b0000: begin arith = 1'b0; r = a; end
            4'b0001: begin arith = 1'b0; r = ~a; end
            4'b0010: y = 16'd1;
            4'b0011: begin y = 16'd1; sub = 1'b1; end
            4'b0100: y = 16'd2;
            4'b0101: begin y = 16'd2; sub = 1'b1; end
            4'b0110: begin x = 16'h0; y = a; sub = 1'b1; end
            4'b1000: ;
            4'b1001: begin arith = 1'b0; r = a | b; end
            4'b1010: c = cin;
            4'b1011: begin c = cin; sub = 1'b1; end
            4'b1100: begin arith = 1'b0; r = a & b; end
            4'b1101, 4'b1111: sub = 1'b1;
            4'b1110: begin arith = 1'b0; r = a ^ b; end
            default: begin arith = 1'b0; r = a; end
        endcase
        if (!w) begin x[15:8] = 8'h0; y[15:8] = 8'h0; end
        if (arith) begin
            full = sub ? ({1'b0, x} - {1'b0, y} - {16'h0, c}) : ({1'b0, x} + {1'b0, y} + {16'h0, c});
            r = full[15:0];
        end
        if (!w) r[15:8] = 8'h0;
        m  = w ? 15 : 7;
        cf = arith & (w ? full[16] : full[8]);
        of = arith & (sub ? ((x[m] != y[m]) && (r[m] != x[m])) : ((x[m] == y[m]) && (r[m] != x[m])));
        af = arith & (x[4] ^ y[4] ^ r[4]);
        return {of, r[m], (r == 16'h0), af, ~^r[7:0], cf, r};
    endfunction

    // Three-stage model: inputs/carry, result, flags.
    logic [15:0] p1_a, p1_b, p2_a, p2_b;
    logic [3:0]  p1_op, p2_op;
    logic        p1_w, p1_c, p2_w, p2_c;
    logic [21:0] s_calc, f_calc;

    always_comb begin
        s_calc = alu_calc(p1_a, p1_b, p1_op, 1'b1, p1_c);
        f_calc = alu_calc(p2_a, p2_b, p2_op, p2_w, p2_c);
    end

    always @(posedge CLKx4) begin
        p1_a <= alu_A; p1_b <= alu_B; p1_op <= alu_op; p1_w <= alu_byteWord; p1_c <= alu_carryIn;
        p2_a <= p1_a;  p2_b <= p1_b;  p2_op <= p1_op;  p2_w <= p1_w;         p2_c <= p1_c;
        alu_S <= s_calc[15:0];
        {f_of, f_sf, f_zf, f_af, f_pf, f_cf} <= f_calc[21:16];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLKx4);
        #1;
    endtask

    task automatic start(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic w);
        check("req_ready_before_accept", {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_word  = w;
        step();
        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_a     = 16'h0;
        bus.req_b     = 16'h0;
        bus.req_word  = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!bus.res_valid && n < 20) begin
            step();
            n++;
        end
        check("res_valid_seen", {31'h0, bus.res_valid}, 32'h1);
    endtask

    task automatic load_flags(input logic [15:0] v);
        bus.flags_wr_en   = 1'b1;
        bus.flags_wr_data = v;
        step();
        bus.flags_wr_en   = 1'b0;
        bus.flags_wr_data = 16'h0;
    endtask

    int n;
    int seen;

    initial begin
        vecs = 0; errs = 0;
        RESET = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 4'h0; bus.req_a = 16'h0; bus.req_b = 16'h0;
        bus.req_word = 1'b0; bus.flags_wr_en = 1'b0; bus.flags_wr_data = 16'h0;
        step();
        step();
        RESET = 1'b0;

        check("rst_flags",     {16'h0, bus.flags},      32'hF002);
        check("rst_req_ready", {31'h0, bus.req_ready},  32'h1);
        check("rst_res_valid", {31'h0, bus.res_valid},  32'h0);
        check("rst_res_data",  {16'h0, bus.res_data},   32'h0);
        check("rst_res_write", {31'h0, bus.res_write},  32'h0);
        check("rst_alu_op",    {28'h0, alu_op},         32'h0);
        check("rst_alu_a",     {16'h0, alu_A},          32'h0);
        check("rst_alu_cin",   {31'h0, alu_carryIn},    32'h0);

        // ADD word 7FFF + 0001
        start(4'b1000, 16'h7FFF, 16'h0001, 1'b1);
        check("add_hold_op", {28'h0, alu_op}, 32'h8);
        check("add_hold_a",  {16'h0, alu_A},  32'h7FFF);
        check("add_ready_low", {31'h0, bus.req_ready}, 32'h0);
        wait_result(n);
        check("add_latency", n + 1, 32'd4);
        check("add_res_data",  {16'h0, bus.res_data},  32'h8000);
        check("add_res_write", {31'h0, bus.res_write}, 32'h1);
        step();
        check("add_pulse_len", {31'h0, bus.res_valid}, 32'h0);
        check("add_flags",     {16'h0, bus.flags},     32'hF896);
        check("add_ready_back", {31'h0, bus.req_ready}, 32'h1);
        check("idle_alu_op",   {28'h0, alu_op},        32'h0);

        // INC byte keeps CF
        load_flags(16'hF003);
        check("load_f003", {16'h0, bus.flags}, 32'hF003);
        start(4'b0010, 16'h12FF, 16'h0000, 1'b0);
        wait_result(n);
        check("inc_res_data", {16'h0, bus.res_data}, 32'h0000);
        step();
        check("inc_flags", {16'h0, bus.flags}, 32'hF057);

        // ADC word with captured CF; CF cleared during HOLD
        start(4'b1010, 16'hFFFF, 16'h0000, 1'b1);
        check("adc_cin", {31'h0, alu_carryIn}, 32'h1);
        load_flags(16'hF002);
        check("adc_hold_load", {16'h0, bus.flags}, 32'hF002);
        check("adc_cin_kept",  {31'h0, alu_carryIn}, 32'h1);
        wait_result(n);
        check("adc_res_data", {16'h0, bus.res_data}, 32'h0000);
        step();
        check("adc_flags", {16'h0, bus.flags}, 32'hF057);

        // CMP 5,5
        start(4'b1111, 16'h0005, 16'h0005, 1'b1);
        wait_result(n);
        check("cmp_res_write", {31'h0, bus.res_write}, 32'h0);
        check("cmp_res_data",  {16'h0, bus.res_data},  32'h0000);
        step();
        check("cmp_flags", {16'h0, bus.flags}, 32'hF046);

        // PASS 1234
        start(4'b0000, 16'h1234, 16'h0000, 1'b1);
        wait_result(n);
        check("pass_res_data",  {16'h0, bus.res_data},  32'h1234);
        check("pass_res_write", {31'h0, bus.res_write}, 32'h1);
        step();
        check("pass_flags", {16'h0, bus.flags}, 32'hF046);

        // Fixed bits forced on direct load
        load_flags(16'h0000);
        check("load_zero", {16'h0, bus.flags}, 32'hF002);

        // Direct load coinciding with COMMIT
        start(4'b1000, 16'h0001, 16'h0001, 1'b1);
        wait_result(n);
        check("coll_res_valid", {31'h0, bus.res_valid}, 32'h1);
        check("coll_res_data",  {16'h0, bus.res_data},  32'h0002);
        load_flags(16'hFFFF);
        check("coll_flags", {16'h0, bus.flags}, 32'hFFD7);

        // Reset during HOLD
        start(4'b1000, 16'h7FFF, 16'h0001, 1'b1);
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("mid_rst_res_valid", {31'h0, bus.res_valid}, 32'h0);
        check("mid_rst_flags",     {16'h0, bus.flags},     32'hF002);
        check("mid_rst_ready",     {31'h0, bus.req_ready}, 32'h1);
        check("mid_rst_alu_op",    {28'h0, alu_op},        32'h0);
        seen = 0;
        for (int i = 0; i < HOLD + 3; i++) begin
            step();
            if (bus.res_valid) seen++;
        end
        check("mid_rst_no_result", seen, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
